// File: rtl/acp_stream_writer_128.sv
// AXI3 write master: chops a 128-bit stream command into INCR bursts
// (<=MAX_BURST beats, never crossing 4 KB), one burst in flight at a time.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake (ready only in IDLE)
//   cmd_addr, cmd_beats         start byte address, number of 16-byte beats
//   st_data/st_valid/st_ready   input stream, passed straight to W channel
//   busy, done, err             status: not idle, completion pulse, sticky error
//   axm_aw*, axm_w*, axm_b*     AXI3 write address / data / response channels

module acp_stream_writer_128 #(
  parameter logic [7:0] AXI_ID    = 8'h00,
  parameter int         MAX_BURST = 16,
  parameter int         CNT_W     = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_addr,
  input  logic [CNT_W-1:0] cmd_beats,
  input  logic [127:0]     st_data,
  input  logic             st_valid,
  output logic             st_ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      axm_awaddr,
  output logic [3:0]       axm_awlen,
  output logic [2:0]       axm_awsize,
  output logic [1:0]       axm_awburst,
  output logic [3:0]       axm_awcache,
  output logic [2:0]       axm_awprot,
  output logic [1:0]       axm_awlock,
  output logic [4:0]       axm_awuser,
  output logic [7:0]       axm_awid,
  output logic             axm_awvalid,
  input  logic             axm_awready,
  output logic [127:0]     axm_wdata,
  output logic [15:0]      axm_wstrb,
  output logic [7:0]       axm_wid,
  output logic             axm_wlast,
  output logic             axm_wvalid,
  input  logic             axm_wready,
  input  logic [7:0]       axm_bid,
  input  logic [1:0]       axm_bresp,
  input  logic             axm_bvalid,
  output logic             axm_bready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [3:0]       lenm1_q, lenm1_d;
  logic [3:0]       beat_q, beat_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic             last_beat;
  logic [4:0]       len5;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^cmd_addr[3:0];
  assign last_beat = (beat_q == lenm1_q);
  assign len5 = {1'b0, lenm1_q} + 5'd1;

  // Burst length minus one: min(MAX_BURST, remaining, beats left in 4 KB page).
  function automatic logic [3:0] calc_lenm1(
    input logic [31:0]      a,
    input logic [CNT_W-1:0] r
  );
    logic [31:0] l;
    logic [31:0] r32;
    logic [31:0] room;
    r32  = 32'(r);
    room = 32'd256 - {24'd0, a[11:4]};
    l    = 32'(MAX_BURST);
    if (r32 < l) l = r32;
    if (room < l) l = room;
    return l[3:0] - 4'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      rem_q   <= '0;
      lenm1_q <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      lenm1_q <= lenm1_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    lenm1_d = lenm1_q;
    beat_d  = beat_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d = {cmd_addr[31:4], 4'h0};
          rem_d  = cmd_beats;
          err_d  = 1'b0;
          if (cmd_beats == '0) begin
            done_d = 1'b1;
          end else begin
            lenm1_d = calc_lenm1(addr_d, rem_d);
            state_d = S_AW;
          end
        end
      end
      S_AW: begin
        if (axm_awready) begin
          beat_d  = '0;
          state_d = S_W;
        end
      end
      S_W: begin
        if (st_valid && axm_wready) begin
          beat_d = beat_q + 4'd1;
          if (last_beat) state_d = S_B;
        end
      end
      S_B: begin
        if (axm_bvalid) begin
          if (axm_bresp != 2'b00 || axm_bid != AXI_ID) err_d = 1'b1;
          rem_d  = rem_q - CNT_W'(len5);
          addr_d = addr_q + {23'd0, len5, 4'h0};
          if (rem_d == '0) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            lenm1_d = calc_lenm1(addr_d, rem_d);
            state_d = S_AW;
          end
        end
      end
    endcase
  end

  always_comb begin
    cmd_ready   = 1'b0;
    busy        = 1'b1;
    axm_awvalid = 1'b0;
    axm_wvalid  = 1'b0;
    axm_wlast   = 1'b0;
    st_ready    = 1'b0;
    axm_bready  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      S_AW: axm_awvalid = 1'b1;
      S_W: begin
        // Zero-latency pass-through between stream and W channel.
        axm_wvalid = st_valid;
        st_ready   = axm_wready;
        axm_wlast  = last_beat;
      end
      S_B: axm_bready = 1'b1;
    endcase
  end

  assign done        = done_q;
  assign err         = err_q;
  assign axm_awaddr  = addr_q;
  assign axm_awlen   = lenm1_q;
  assign axm_awsize  = 3'b100;
  assign axm_awburst = 2'b01;
  assign axm_awcache = 4'b0011;
  assign axm_awprot  = 3'b000;
  assign axm_awlock  = 2'b00;
  assign axm_awuser  = 5'b00001;
  assign axm_awid    = AXI_ID;
  assign axm_wdata   = st_data;
  assign axm_wstrb   = 16'hFFFF;
  assign axm_wid     = AXI_ID;

endmodule
